prbs_checker: RTL and testbench
===============================

// Module: prbs_checker
// PURPOSE
//   Serial PRBS checker that consumes the MSB-first bit stream leaving the 8-bit shift register.
//   - Self-synchronises a local Fibonacci LFSR to the incoming bits.
//   - Declares lock, then counts bit errors against the free-running prediction.
//   - Drops lock when the error density gets too high.
//   - Sits directly downstream of the shift register's serial output; status goes to board LEDs/debug.
// PARAMETERS
//   WIDTH     8      LFSR length in bits
//   TAPS      8'hB8  feedback mask, x^8+x^6+x^5+x^4+1; predicted bit = ^(s & TAPS)
//   LOCK_CNT  16     consecutive matching bits required to lock (1..255)
//   LOSS_WIN  32     loss-detection window length in checked bits (power of 2)
//   LOSS_THR  4      errors within one window that force loss of lock (1..LOSS_WIN)
//   ERR_W     16     error counter width
// PORTS
//   clk          in   1          clock
//   rst_n        in   1          reset, asynchronous, active-low
//   i_bit        in   1          serial data bit (shift register serial out)
//   i_bit_en     in   1          i_bit valid this cycle; no state changes when low
//   i_clr_err    in   1          synchronous clear of o_err_cnt
//   o_state      out  2          0 HUNT, 1 VERIFY, 2 LOCKED
//   o_locked     out  1          o_state == LOCKED
//   o_err_pulse  out  1          one-cycle pulse per mismatched bit while LOCKED
//   o_err_cnt    out  ERR_W      saturating error count
// BEHAVIOUR
//   - Reset: s=0, state=HUNT, all counters 0, o_locked=0, o_err_pulse=0, o_err_cnt=0.
//   - Local register s shifts left; the new bit enters s[0]; p = ^(s & TAPS). Shifts occur only on i_bit_en.
//   - HUNT: shift i_bit into s; after WIDTH accepted bits -> VERIFY, good=0.
//   - VERIFY: compare i_bit to p, then shift i_bit into s (self-sync).
//     - Match with s!=0: good++. Mismatch or s==0: good=0.
//     - good reaching LOCK_CNT -> LOCKED; window and window-error counts cleared.
//   - LOCKED: shift p (not i_bit) into s; the LFSR free-runs. Mismatch -> o_err_pulse=1 next cycle,
//     o_err_cnt++ (saturates at all-ones), win_err++.
//     - Window counter counts checked bits; when it wraps at LOSS_WIN, win_err is cleared.
//     - win_err reaching LOSS_THR -> HUNT. s is kept, bit counter is cleared, o_err_cnt is kept.
//   - All outputs are registered; 1-cycle latency from the i_bit_en sample to o_state/o_err_* update.
//   - Error on the last window bit: the error counts first, then the window resets.
//     Reaching LOSS_THR on that bit still drops lock.
//   - i_clr_err and an error in the same cycle: o_err_cnt=0 (clear wins); o_err_pulse still asserts.
//   - i_bit_en low: every register holds; o_err_pulse=0.
//   - rst_n low mid-stream: immediate return to reset values; no partial lock survives.
// CONFIGURATION
//   PRBS_CHK_BYTE_OUT_EN defined: adds ports o_byte[7:0] and o_byte_vld.
//     - Every 8th accepted bit while LOCKED, o_byte = last 8 received bits MSB-first, with a 1-cycle o_byte_vld pulse.
//     - Byte phase restarts on entry to LOCKED.
//     - o_byte resets to 8'h00.
//   Undefined: ports absent, no byte logic.
// STRUCTURE
//   prbs_pkg.vh (shared, also used by the LFSR generator):
//     - state encodings ST_HUNT/ST_VERIFY/ST_LOCKED
//     - default TAPS 8'hB8 and WIDTH 8
//     - function prbs_next(s, taps)
//   Sub-module prbs_err_counter: ERR_W saturating counter with inc/clr, clear priority.
//   Top: FSM, local LFSR, good/window counters.
// TESTING
//   1. Reset 3 cycles, i_bit_en=0 -> o_state=0, o_err_cnt=0, o_err_pulse=0, no change for 20 cycles.
//   2. Clean PRBS from generator seed 8'h01, i_bit_en=1 -> VERIFY after 8 bits;
//      LOCKED after bit 24 (8+16); o_err_cnt stays 0 for 1000 bits.
//   3. While LOCKED, flip 1 bit at bit 100 -> exactly one o_err_pulse, o_err_cnt=1, o_locked stays 1.
//   4. While LOCKED, flip 4 bits within one 32-bit window -> HUNT the cycle after the 4th error;
//      relock 24 bits later; o_err_cnt=4 held.
//   5. Constant 0 stream for 200 bits -> never leaves VERIFY; o_locked=0.
//   6. o_err_cnt=5 plus i_clr_err coincident with an injected error -> o_err_cnt=0, o_err_pulse=1.
//      With ERR_W=4, 20 errors -> count saturates at 15.

Source files
------------

// File: rtl/prbs_pkg.sv
// Shared PRBS definitions: state encodings, default polynomial and the
// one-step Fibonacci advance used by both the generator and the checker.
package prbs_pkg;

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCKED = 2'd2
  } prbs_state_e;

  localparam int         PRBS_WIDTH = 8;
  localparam logic [7:0] PRBS_TAPS  = 8'hB8;  // x^8+x^6+x^5+x^4+1

  function automatic logic [7:0] prbs_next(input logic [7:0] s, input logic [7:0] taps);
    return {s[6:0], ^(s & taps)};
  endfunction

endpackage

// File: rtl/prbs_err_counter.sv
// Saturating error counter; a clear in the same cycle as an increment wins.
module prbs_err_counter #(
  parameter int ERR_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [ERR_W-1:0] cnt_o
);

  logic [ERR_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)                    cnt_d = '0;
    else if (inc_i && ~&cnt_q)    cnt_d = cnt_q + ERR_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/prbs_checker.sv
// Self-synchronising serial PRBS checker (HUNT -> VERIFY -> LOCKED).
// Optional byte output enabled by defining PRBS_CHK_BYTE_OUT_EN.
module prbs_checker
  import prbs_pkg::*;
#(
  parameter int               WIDTH    = PRBS_WIDTH,
  parameter logic [WIDTH-1:0] TAPS     = PRBS_TAPS,
  parameter int               LOCK_CNT = 16,
  parameter int               LOSS_WIN = 32,
  parameter int               LOSS_THR = 4,
  parameter int               ERR_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_bit,
  input  logic             i_bit_en,
  input  logic             i_clr_err,
  output logic [1:0]       o_state,
  output logic             o_locked,
  output logic             o_err_pulse,
  output logic [ERR_W-1:0] o_err_cnt
`ifdef PRBS_CHK_BYTE_OUT_EN
  ,
  output logic [7:0]       o_byte,
  output logic             o_byte_vld
`endif
);

  localparam int BIT_W  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int GOOD_W = $clog2(LOCK_CNT + 1);
  localparam int WIN_W  = (LOSS_WIN > 1) ? $clog2(LOSS_WIN) : 1;
  localparam int WERR_W = $clog2(LOSS_THR + 1);

  prbs_state_e       state_q, state_d;
  logic [WIDTH-1:0]  s_q, s_d;
  logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [GOOD_W-1:0] good_q, good_d, good_nxt;
  logic [WIN_W-1:0]  win_q, win_d;
  logic [WERR_W-1:0] werr_q, werr_d, werr_nxt;
  logic              err_pulse_q, err_pulse_d;
  logic              locked_q, locked_d;
  logic              p, mism, s_zero, err_ev;

  assign p        = ^(s_q & TAPS);
  assign mism     = i_bit ^ p;
  assign s_zero   = (s_q == '0);
  // An all-zero register predicts zeros forever, so it never earns credit.
  assign good_nxt = (!mism && !s_zero) ? good_q + GOOD_W'(1) : '0;
  assign werr_nxt = werr_q + WERR_W'(mism);
  assign err_ev   = i_bit_en && (state_q == ST_LOCKED) && mism;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_HUNT;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (i_bit_en) begin
      case (state_q)
        ST_HUNT:   if (bit_cnt_q == BIT_W'(WIDTH - 1))    state_d = ST_VERIFY;
        ST_VERIFY: if (good_nxt == GOOD_W'(LOCK_CNT))     state_d = ST_LOCKED;
        ST_LOCKED: if (werr_nxt == WERR_W'(LOSS_THR))     state_d = ST_HUNT;
        default:                                          state_d = ST_HUNT;
      endcase
    end
  end

  always_comb begin
    s_d         = s_q;
    bit_cnt_d   = bit_cnt_q;
    good_d      = good_q;
    win_d       = win_q;
    werr_d      = werr_q;
    err_pulse_d = err_ev;
    locked_d    = (state_d == ST_LOCKED);
    if (i_bit_en) begin
      case (state_q)
        ST_HUNT: begin
          s_d       = {s_q[WIDTH-2:0], i_bit};
          bit_cnt_d = (bit_cnt_q == BIT_W'(WIDTH - 1)) ? '0 : bit_cnt_q + BIT_W'(1);
          good_d    = '0;
        end
        ST_VERIFY: begin
          s_d       = {s_q[WIDTH-2:0], i_bit};
          good_d    = good_nxt;
          win_d     = '0;
          werr_d    = '0;
          bit_cnt_d = '0;
        end
        ST_LOCKED: begin
          // Free-run on the prediction so line errors never corrupt s.
          s_d = {s_q[WIDTH-2:0], p};
          if (werr_nxt == WERR_W'(LOSS_THR)) begin
            win_d     = '0;
            werr_d    = '0;
            good_d    = '0;
            bit_cnt_d = '0;
          end else if (win_q == WIN_W'(LOSS_WIN - 1)) begin
            win_d  = '0;
            werr_d = '0;
          end else begin
            win_d  = win_q + WIN_W'(1);
            werr_d = werr_nxt;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q         <= '0;
      bit_cnt_q   <= '0;
      good_q      <= '0;
      win_q       <= '0;
      werr_q      <= '0;
      err_pulse_q <= 1'b0;
      locked_q    <= 1'b0;
    end else begin
      s_q         <= s_d;
      bit_cnt_q   <= bit_cnt_d;
      good_q      <= good_d;
      win_q       <= win_d;
      werr_q      <= werr_d;
      err_pulse_q <= err_pulse_d;
      locked_q    <= locked_d;
    end
  end

  prbs_err_counter #(.ERR_W(ERR_W)) u_err_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc_i (err_ev),
    .clr_i (i_clr_err && i_bit_en),
    .cnt_o (o_err_cnt)
  );

  assign o_state     = state_q;
  assign o_locked    = locked_q;
  assign o_err_pulse = err_pulse_q;

`ifdef PRBS_CHK_BYTE_OUT_EN
  logic [7:0] rx_q, rx_d, byte_q, byte_d;
  logic [2:0] phase_q, phase_d;
  logic       byte_vld_q, byte_vld_d;

  // Phase is held at zero outside LOCKED so every lock starts a fresh byte.
  always_comb begin
    rx_d       = rx_q;
    phase_d    = phase_q;
    byte_d     = byte_q;
    byte_vld_d = 1'b0;
    if (i_bit_en) begin
      rx_d = {rx_q[6:0], i_bit};
      if (state_q != ST_LOCKED) begin
        phase_d = '0;
      end else begin
        phase_d = phase_q + 3'd1;
        if (phase_q == 3'd7) begin
          byte_d     = {rx_q[6:0], i_bit};
          byte_vld_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_q       <= '0;
      phase_q    <= '0;
      byte_q     <= '0;
      byte_vld_q <= 1'b0;
    end else begin
      rx_q       <= rx_d;
      phase_q    <= phase_d;
      byte_q     <= byte_d;
      byte_vld_q <= byte_vld_d;
    end
  end

  assign o_byte     = byte_q;
  assign o_byte_vld = byte_vld_q;
`endif

endmodule

// File: tb/tb_prbs_checker.sv
// Bench for prbs_checker: two instances (16- and 4-bit error counters) driven
// in lockstep and checked against a stream-history reference model.
module tb_prbs_checker;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       i_bit, i_bit_en, i_clr_err;
  logic [1:0] st_a, st_b;
  logic       lk_a, lk_b, pl_a, pl_b;
  logic [15:0] cnt_a;
  logic [3:0]  cnt_b;
`ifdef PRBS_CHK_BYTE_OUT_EN
  logic [7:0] byte_a, byte_b;
  logic       bv_a, bv_b;
`endif

  always #5 clk = ~clk;

  prbs_checker dut (
    .clk(clk), .rst_n(rst_n), .i_bit(i_bit), .i_bit_en(i_bit_en), .i_clr_err(i_clr_err),
    .o_state(st_a), .o_locked(lk_a), .o_err_pulse(pl_a), .o_err_cnt(cnt_a)
`ifdef PRBS_CHK_BYTE_OUT_EN
    , .o_byte(byte_a), .o_byte_vld(bv_a)
`endif
  );

  prbs_checker #(.ERR_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .i_bit(i_bit), .i_bit_en(i_bit_en), .i_clr_err(i_clr_err),
    .o_state(st_b), .o_locked(lk_b), .o_err_pulse(pl_b), .o_err_cnt(cnt_b)
`ifdef PRBS_CHK_BYTE_OUT_EN
    , .o_byte(byte_b), .o_byte_vld(bv_b)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Reference model: loc is the history of bits the checker's local LFSR holds.
  bit loc[$];
  int m_mode, m_hcnt, m_good, m_win, m_werr, m_cnt16, m_cnt4;
  bit m_pulse;

  function automatic bit pred();
    int n = loc.size();
    return loc[n-8] ^ loc[n-6] ^ loc[n-5] ^ loc[n-4];
  endfunction

  function automatic bit last8_zero();
    int n = loc.size();
    for (int i = 1; i <= 8; i++) if (loc[n-i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    loc = {};
    for (int i = 0; i < 8; i++) loc.push_back(1'b0);
    m_mode = 0; m_hcnt = 0; m_good = 0; m_win = 0; m_werr = 0;
    m_cnt16 = 0; m_cnt4 = 0; m_pulse = 1'b0;
  endtask

  task automatic model_bit(input bit b, input bit clr);
    bit p, z;
    m_pulse = 1'b0;
    p = pred();
    z = last8_zero();
    if (m_mode == 0) begin
      loc.push_back(b);
      m_hcnt++;
      if (m_hcnt == 8) begin m_mode = 1; m_good = 0; end
    end else if (m_mode == 1) begin
      loc.push_back(b);
      m_good = (b == p && !z) ? m_good + 1 : 0;
      if (m_good == 16) begin m_mode = 2; m_win = 0; m_werr = 0; end
    end else begin
      loc.push_back(p);
      if (b != p) begin
        m_pulse = 1'b1;
        m_werr++;
        if (m_cnt16 < 65535) m_cnt16++;
        if (m_cnt4 < 15) m_cnt4++;
      end
      m_win++;
      if (m_werr >= 4) begin m_mode = 0; m_hcnt = 0; end
      else if (m_win == 32) begin m_win = 0; m_werr = 0; end
    end
    if (clr) begin m_cnt16 = 0; m_cnt4 = 0; end
    if (loc.size() > 32) void'(loc.pop_front());
  endtask

  // Generator: x[k+8] = x[k]^x[k+2]^x[k+3]^x[k+4], seed bits emitted MSB first.
  bit gq[$];

  task automatic gen_seed(input logic [7:0] seed);
    gq = {};
    for (int i = 7; i >= 0; i--) gq.push_back(seed[i]);
  endtask

  function automatic bit gen_next();
    bit b = gq[0];
    gq.push_back(gq[0] ^ gq[2] ^ gq[3] ^ gq[4]);
    void'(gq.pop_front());
    return b;
  endfunction

  task automatic compare_all();
    chk("state",   int'(st_a),  m_mode);
    chk("locked",  int'(lk_a),  int'(m_mode == 2));
    chk("pulse",   int'(pl_a),  int'(m_pulse));
    chk("cnt16",   int'(cnt_a), m_cnt16);
    chk("state4",  int'(st_b),  m_mode);
    chk("cnt4",    int'(cnt_b), m_cnt4);
  endtask

  task automatic step(input bit b, input bit en, input bit clr);
    i_bit = b; i_bit_en = en; i_clr_err = clr;
    if (en) model_bit(b, clr);
    else    m_pulse = 1'b0;
    @(posedge clk); #1;
    compare_all();
  endtask

  task automatic do_reset();
    rst_n = 1'b0; i_bit = 1'b0; i_bit_en = 1'b0; i_clr_err = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  bit saw_lock;

  initial begin
    // 1: reset and idle
    do_reset();
    chk("rst_state", int'(st_a), 0);
    chk("rst_cnt", int'(cnt_a), 0);
    chk("rst_pulse", int'(pl_a), 0);
    for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 1'b0);
    chk("idle_state", int'(st_a), 0);

    // 2: clean stream from seed 8'h01
    gen_seed(8'h01);
    for (int i = 1; i <= 1000; i++) begin
      step(gen_next(), 1'b1, 1'b0);
      if (i == 8)  chk("verify_at_8", int'(st_a), 1);
      if (i == 23) chk("verify_at_23", int'(st_a), 1);
      if (i == 24) chk("lock_at_24", int'(st_a), 2);
    end
    chk("clean_cnt", int'(cnt_a), 0);

    // 3: single flipped bit
    step(gen_next() ^ 1'b1, 1'b1, 1'b0);
    chk("single_pulse", int'(pl_a), 1);
    step(gen_next(), 1'b1, 1'b0);
    chk("single_pulse_end", int'(pl_a), 0);
    chk("single_cnt", int'(cnt_a), 1);
    chk("single_locked", int'(lk_a), 1);

    // 4: four errors in one window drop lock, then relock
    for (int i = 0; i < 64 && m_win != 0; i++) step(gen_next(), 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) step(gen_next() ^ 1'b1, 1'b1, 1'b0);
    chk("hunt_after_4", int'(st_a), 0);
    for (int i = 1; i <= 24; i++) begin
      step(gen_next(), 1'b1, 1'b0);
      if (i == 23) chk("relock_not_yet", int'(lk_a), 0);
    end
    chk("relock", int'(lk_a), 1);
    chk("held_cnt", int'(cnt_a), 5);

    // 6a: clear coincident with an error
    step(gen_next() ^ 1'b1, 1'b1, 1'b1);
    chk("clr_cnt", int'(cnt_a), 0);
    chk("clr_pulse", int'(pl_a), 1);

    // 6b: ~25 errors at two per window; 4-bit counter saturates
    for (int i = 0; i < 400; i++)
      step(gen_next() ^ bit'(m_win == 3 || m_win == 17), 1'b1, 1'b0);
    chk("sat4", int'(cnt_b), 15);
    chk("sat_locked", int'(lk_a), 1);

    // async reset mid-stream
    #2 rst_n = 1'b0;
    #1;
    chk("arst_state", int'(st_a), 0);
    chk("arst_locked", int'(lk_a), 0);
    chk("arst_cnt", int'(cnt_a), 0);
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;

    // 5: all-zero stream never locks
    saw_lock = 1'b0;
    for (int i = 0; i < 200; i++) begin
      step(1'b0, 1'b1, 1'b0);
      if (lk_a) saw_lock = 1'b1;
    end
    chk("zero_state", int'(st_a), 1);
    chk("zero_no_lock", int'(saw_lock), 0);

    // random: gaps in i_bit_en, sparse errors and clears
    do_reset();
    gen_seed(8'($urandom_range(1, 255)));
    for (int i = 0; i < 3000; i++) begin
      bit en, b, clr;
      en  = ($urandom_range(0, 3) != 0);
      b   = en ? (gen_next() ^ bit'($urandom_range(0, 39) == 0)) : bit'($urandom_range(0, 1));
      clr = en && ($urandom_range(0, 199) == 0);
      step(b, en, clr);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
